// File: rtl/rv_exec_unit.sv
// RV32IM execute unit: single-cycle ALU, iterative multiplier and restoring divider
// behind a valid/ready handshake on both the operand and the result side.
module rv_exec_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    localparam int SHW       = $clog2(XLEN);
    localparam int CW        = SHW + 1;
    localparam int MUL_STEPS = XLEN / MUL_BITS;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STEPS - 1);
    localparam logic [CW-1:0] DIV_FIX  = CW'(XLEN);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic          accept, out_fire, start_iter;

    // decode of the operation currently presented
    logic            is_m, is_mul, is_div;
    logic            a_sgn, b_sgn, a_neg, b_neg, neg_q, neg_r;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, div_bypass;
    logic [XLEN-1:0] bypass_res, alu_res;

    // iteration state, captured on acceptance
    logic [2:0]        f3_q;
    logic              neg_q_q, neg_r_q;
    logic [2*XLEN-1:0] acc, mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   rem, quo, dvsr;

    logic [2*XLEN-1:0] dig_ext, acc_nxt, prod;
    logic [XLEN-1:0]   mul_res, quo_fix, rem_fix, div_res;
    logic [XLEN:0]     rem_sh, diff;

    function automatic logic [XLEN-1:0] alu_op(input logic [2:0] f3, input logic alt,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic signed [XLEN-1:0] sra;
        logic [SHW-1:0]         sh;
        logic [XLEN-1:0]        r;
        sa  = a;
        sb  = b;
        sh  = b[SHW-1:0];
        sra = sa >>> sh;
        case (f3)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << sh;
            3'd2:    r = {{(XLEN-1){1'b0}}, sa < sb};
            3'd3:    r = {{(XLEN-1){1'b0}}, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? $unsigned(sra) : a >> sh;
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    assign in_ready   = !rst && (state == S_IDLE) && (!out_valid || out_ready);
    assign busy       = (state == S_MUL) || (state == S_DIV);
    assign accept     = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign start_iter = is_mul || (is_div && !div_bypass);

    // operand decode: signedness, magnitudes, divider shortcuts and the ALU result
    always_comb begin
        is_m   = (in_opcode == OPC_OP) && (in_funct7 == F7_MULDIV);
        is_mul = is_m && !in_funct3[2];
        is_div = is_m && in_funct3[2];
        if (is_div) begin
            a_sgn = !in_funct3[0];
            b_sgn = !in_funct3[0];
        end else begin
            a_sgn = (in_funct3[1:0] != 2'b11);
            b_sgn = !in_funct3[1];
        end
        a_neg = a_sgn && in_a[XLEN-1];
        b_neg = b_sgn && in_b[XLEN-1];
        mag_a = a_neg ? -in_a : in_a;
        mag_b = b_neg ? -in_b : in_b;
        neg_q = a_neg ^ b_neg;
        neg_r = a_neg;

        div_zero   = (in_b == '0);
        div_ovf    = !in_funct3[0] && (in_a == INT_MIN) && (in_b == '1);
        div_bypass = div_zero || div_ovf;
        if (div_zero) bypass_res = in_funct3[1] ? in_a : '1;
        else          bypass_res = in_funct3[1] ? '0 : in_a;

        alu_res = '0;
        case (in_opcode)
            OPC_OP: begin
                if (in_funct7 == F7_BASE)
                    alu_res = alu_op(in_funct3, 1'b0, in_a, in_b);
                else if (in_funct7 == F7_ALT && (in_funct3 == 3'd0 || in_funct3 == 3'd5))
                    alu_res = alu_op(in_funct3, 1'b1, in_a, in_b);
            end
            OPC_OPIMM:  alu_res = alu_op(in_funct3, (in_funct3 == 3'd5) && (in_funct7 == F7_ALT),
                                         in_a, in_b);
            OPC_LUI:    alu_res = in_b;
            OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_BRANCH: alu_res = in_a + in_b;
            default:    alu_res = '0;
        endcase
    end

    // one radix-2^MUL_BITS multiply step and one restoring divide step
    assign dig_ext = {{(2*XLEN-MUL_BITS){1'b0}}, mplier[MUL_BITS-1:0]};
    assign acc_nxt = acc + mcand * dig_ext;
    assign prod    = neg_q_q ? -acc_nxt : acc_nxt;
    assign mul_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    assign rem_sh  = {rem, quo[XLEN-1]};
    assign diff    = rem_sh - {1'b0, dvsr};
    assign quo_fix = neg_q_q ? -quo : quo;
    assign rem_fix = neg_r_q ? -rem : rem;
    assign div_res = f3_q[1] ? rem_fix : quo_fix;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul)                     state_nxt = S_MUL;
                    else if (is_div && !div_bypass) state_nxt = S_DIV;
                end
            end
            S_MUL:   if (cnt == MUL_LAST) state_nxt = S_DONE;
            S_DIV:   if (cnt == DIV_FIX)  state_nxt = S_DONE;
            default: if (out_fire)        state_nxt = S_IDLE;
        endcase
    end

    // step counter and the registered result with its valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            if (accept)    cnt <= '0;
            else if (busy) cnt <= cnt + CW'(1);

            if (out_fire) out_valid <= 1'b0;

            if (accept && !start_iter) begin
                out_valid  <= 1'b1;
                out_result <= is_div ? bypass_res : alu_res;
            end else if (state == S_MUL && cnt == MUL_LAST) begin
                out_valid  <= 1'b1;
                out_result <= mul_res;
            end else if (state == S_DIV && cnt == DIV_FIX) begin
                out_valid  <= 1'b1;
                out_result <= div_res;
            end
        end
    end

    // multiply/divide working registers; the last divide cycle only applies signs
    always_ff @(posedge clk) begin
        if (accept) begin
            f3_q    <= in_funct3;
            neg_q_q <= neg_q;
            neg_r_q <= neg_r;
            acc     <= '0;
            mcand   <= {{XLEN{1'b0}}, mag_a};
            mplier  <= mag_b;
            rem     <= '0;
            quo     <= mag_a;
            dvsr    <= mag_b;
        end else if (state == S_MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << MUL_BITS;
            mplier <= mplier >> MUL_BITS;
        end else if (state == S_DIV && cnt != DIV_FIX) begin
            quo <= {quo[XLEN-2:0], !diff[XLEN]};
            rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        end
    end

endmodule

// File: tb/tb_rv_exec_unit.sv
// Bench for rv_exec_unit: directed cases with hand-derived results, then random
// operations against a behavioural RV32IM model.
module tb_rv_exec_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    rv_exec_unit #(.XLEN(32), .MUL_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa, sb, sh;
        sa = a;
        sb = b;
        sh = int'(b & 32'd31);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'(sa >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
        longint ea, eb;
        logic [63:0] p;
        int sa, sb;
        logic [31:0] q, rm;
        sa  = a;
        sb  = b;
        r   = 32'd0;
        lat = 1;
        case (op)
            7'b0110011: begin
                if (f7 == 7'h01 && !f3[2]) begin
                    ea  = (f3 != 3'd3) ? longint'(sa) : longint'({32'd0, a});
                    eb  = (f3 < 3'd2)  ? longint'(sb) : longint'({32'd0, b});
                    p   = ea * eb;
                    r   = (f3 == 3'd0) ? p[31:0] : p[63:32];
                    lat = 9;
                end else if (f7 == 7'h01) begin
                    lat = 34;
                    if (b == 32'd0) begin
                        q = 32'hFFFF_FFFF; rm = a; lat = 1;
                    end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        q = a; rm = 32'd0; lat = 1;
                    end else if (!f3[0]) begin
                        q = sa / sb; rm = sa % sb;
                    end else begin
                        q = a / b; rm = a % b;
                    end
                    r = f3[1] ? rm : q;
                end else if (f7 == 7'h00) begin
                    r = alu_ref(f3, 1'b0, a, b);
                end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    r = alu_ref(f3, 1'b1, a, b);
                end
            end
            7'b0010011: r = alu_ref(f3, (f3 == 3'd5) && (f7 == 7'h20), a, b);
            7'b0110111: r = b;
            7'b0010111, 7'b0000011, 7'b0100011, 7'b1100011: r = a + b;
            default: r = 32'd0;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input int el);
        int lat;
        int guard;
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = op;
        in_funct3 = f3;
        in_funct7 = f7;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, " busy"}, {31'd0, busy}, (el > 1) ? 32'd1 : 32'd0);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(el));
        check({tag, " result"}, out_result, er);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b, er;
        int          el, rises;
        logic [6:0]  bad_ops [4];
        logic [6:0]  misc_ops [4];

        bad_ops[0]  = 7'b1101111;
        bad_ops[1]  = 7'b0001111;
        bad_ops[2]  = 7'b1110011;
        bad_ops[3]  = 7'b0000000;
        misc_ops[0] = 7'b0010111;
        misc_ops[1] = 7'b0000011;
        misc_ops[2] = 7'b0100011;
        misc_ops[3] = 7'b1100011;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid",  {31'd0, out_valid}, 32'd0);
        check("reset out_result", out_result, 32'd0);
        check("reset busy",       {31'd0, busy}, 32'd0);
        check("reset in_ready",   {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", {31'd0, in_ready}, 32'd1);

        // directed cases
        run_op("ADD",    7'b0110011, 3'd0, 7'h00, 32'd33, 32'd5, 32'd38, 1);
        run_op("SUB",    7'b0110011, 3'd0, 7'h20, 32'd33, 32'd5, 32'd28, 1);
        run_op("SRA",    7'b0110011, 3'd5, 7'h20, 32'hF0F0_F0F0, 32'd16, 32'hFFFF_F0F0, 1);
        run_op("SRAI",   7'b0010011, 3'd5, 7'h20, 32'hF0F0_F0F0, 32'h410, 32'hFFFF_F0F0, 1);
        run_op("SRLI",   7'b0010011, 3'd5, 7'h00, 32'hF0F0_F0F0, 32'd16, 32'h0000_F0F0, 1);
        run_op("SLT",    7'b0110011, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("SLTU",   7'b0110011, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("LUI",    7'b0110111, 3'd0, 7'h00, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000, 1);
        run_op("AUIPC",  7'b0010111, 3'd0, 7'h00, 32'h0000_1000, 32'h0002_0000, 32'h0002_1000, 1);
        run_op("BADOP",  7'b1101111, 3'd0, 7'h00, 32'd9, 32'd9, 32'd0, 1);
        run_op("BADF7",  7'b0110011, 3'd4, 7'h20, 32'd9, 32'd3, 32'd0, 1);
        run_op("MUL",    7'b0110011, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 9);
        run_op("MULH",   7'b0110011, 3'd1, 7'h01, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 9);
        run_op("MULHU",  7'b0110011, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 9);
        run_op("MULHSU", 7'b0110011, 3'd2, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9);
        run_op("DIV",    7'b0110011, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("REM",    7'b0110011, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("DIVU",   7'b0110011, 3'd5, 7'h01, 32'd100, 32'd7, 32'd14, 34);
        run_op("DIVU0",  7'b0110011, 3'd5, 7'h01, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("REMU0",  7'b0110011, 3'd7, 7'h01, 32'd7, 32'd0, 32'd7, 1);
        run_op("REMOVF", 7'b0110011, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("DIVOVF", 7'b0110011, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

        // backpressure: result held, input blocked, then back-to-back handshake
        @(negedge clk);
        in_valid = 1'b1; in_opcode = 7'b0110011; in_funct3 = 3'd0; in_funct7 = 7'h00;
        in_a = 32'd33; in_b = 32'd5; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp first result", out_result, 32'd38);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp held result", out_result, 32'd38);
            check("bp held valid",  {31'd0, out_valid}, 32'd1);
            check("bp in_ready low", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b1; in_funct7 = 7'h20; out_ready = 1'b1;
        #1;
        check("bp in_ready in handshake", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp next valid",  {31'd0, out_valid}, 32'd1);
        check("bp next result", out_result, 32'd28);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // reset in the middle of a divide
        @(negedge clk);
        in_valid = 1'b1; in_opcode = 7'b0110011; in_funct3 = 3'd4; in_funct7 = 7'h01;
        in_a = 32'd1000; in_b = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort busy before rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort in_ready in rst", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort busy",      {31'd0, busy}, 32'd0);
        check("abort in_ready",  {31'd0, in_ready}, 32'd1);
        rises = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) rises++;
        end
        check("abort no result", 32'(rises), 32'd0);
        run_op("post-abort ADD", 7'b0110011, 3'd0, 7'h00, 32'd1, 32'd2, 32'd3, 1);

        // randomized operations against the model
        for (int n = 0; n < 40; n++) begin
            a  = pick_val();
            b  = pick_val();
            f3 = 3'($urandom_range(0, 7));
            f7 = 7'h00;
            case ($urandom_range(0, 11))
                0:  op = 7'b0110011;
                1:  begin op = 7'b0110011; f7 = 7'h20; f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5; end
                2:  begin op = 7'b0010011; f7 = 7'($urandom); if (f3 == 3'd5 && $urandom_range(0, 1) == 0) f7 = 7'h20; end
                3:  op = 7'b0110111;
                4:  op = misc_ops[$urandom_range(0, 3)];
                5, 6: begin op = 7'b0110011; f7 = 7'h01; f3 = 3'($urandom_range(0, 3)); end
                7, 8: begin
                    op = 7'b0110011; f7 = 7'h01; f3 = 3'($urandom_range(4, 7));
                    if ($urandom_range(0, 5) == 0) b = 32'd0;
                end
                9:  op = bad_ops[$urandom_range(0, 3)];
                10: begin op = 7'b0110011; f7 = 7'h10; end
                default: begin op = 7'b0110011; f7 = 7'h20; f3 = 3'd1; end
            endcase
            model(op, f3, f7, a, b, er, el);
            run_op($sformatf("rand%0d op=%b f3=%0d f7=%h a=%h b=%h", n, op, f3, f7, a, b),
                   op, f3, f7, a, b, er, el);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
